// File: rtl/bram_pkg.sv
// Shared constants, clear-FSM state encoding and parity helper for the stage BRAM.
package bram_pkg;

   localparam int MAX_RD_LATENCY = 4;
   localparam int PAR_MAX_W      = 256;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Callers zero-extend their word to PAR_MAX_W; padding zeros leave the parity unchanged.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read-return pipeline: LAT register stages of valid/data; data stages
// only load when a valid word moves in, so the output holds its last value while idle.
module bram_rd_pipe #(
   parameter int W   = 72,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic [LAT-1:0] v_q;
   logic [W-1:0]   d_q [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < LAT; i++) d_q[i] <= '0;
      end else begin
         v_q[0] <= valid_i;
         if (valid_i) d_q[0] <= data_i;
         for (int i = 1; i < LAT; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) d_q[i] <= d_q[i-1];
         end
      end
   end

   assign valid_o = v_q[LAT-1];
   assign data_o  = d_q[LAT-1];

endmodule

// File: rtl/bram_tdp_pipe.sv
// Single-clock true dual-port stage RAM with read-latency pipeline, post-reset clear
// engine and write-write collision reporting. Define BRAM_TDP_PIPE_PARITY_EN for a stored parity bit.
module bram_tdp_pipe
   import bram_pkg::*;
#(
   parameter int STAGE_ID       = 0,
   parameter int DATA           = 72,
   parameter int ADDR           = 10,
   parameter int RD_LATENCY     = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter int MEMINIT        = 0,
   parameter     MEMINIT_DIR      = "../scalable-pipelined-lookup-c/output/",
   parameter     MEMINIT_FILENAME = "stage00.mem",
   parameter     RAMSTYLE         = "auto"
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            init_busy,
   input  logic            a_en,
   input  logic            a_wr,
   input  logic [ADDR-1:0] a_addr,
   input  logic [DATA-1:0] a_din,
   output logic [DATA-1:0] a_dout,
   output logic            a_valid,
   input  logic            b_en,
   input  logic            b_wr,
   input  logic [ADDR-1:0] b_addr,
   input  logic [DATA-1:0] b_din,
   output logic [DATA-1:0] b_dout,
   output logic            b_valid,
`ifdef BRAM_TDP_PIPE_PARITY_EN
   output logic            a_perr,
   output logic            b_perr,
`endif
   output logic            coll
);

   localparam int DEPTH = 2**ADDR;
`ifdef BRAM_TDP_PIPE_PARITY_EN
   localparam int W = DATA + 1;
`else
   localparam int W = DATA;
`endif
   localparam bit              CLR_EN    = (CLEAR_ON_RESET != 0) && (MEMINIT == 0);
   localparam bit              WF        = (WRITE_FIRST != 0);
   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
   localparam bit              CFG_OK    = (STAGE_ID >= 0) && (RD_LATENCY >= 1) &&
                                           (RD_LATENCY <= MAX_RD_LATENCY);

   if (!CFG_OK) begin : g_cfg_err
      $error("bram_tdp_pipe: illegal configuration (RD_LATENCY must be 1..4)");
   end

   (* ram_style = RAMSTYLE *) logic [W-1:0] mem [DEPTH];

   state_e          state_q, state_d;
   logic [ADDR-1:0] clr_addr_q, clr_addr_d;
   logic            clr_we;
   logic            coll_q, coll_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we     = 1'b0;
      if (state_q == ST_CLEAR) begin
         clr_we     = 1'b1;
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLR_EN ? ST_CLEAR : ST_READY;
         clr_addr_q <= '0;
         coll_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         coll_q     <= coll_d;
      end
   end

   logic            ready;
   logic            a_acc, b_acc, a_we, b_we;
   logic [W-1:0]    a_word, b_word;

   assign ready     = (state_q == ST_READY);
   assign init_busy = (state_q == ST_CLEAR);
   assign a_acc     = ready & a_en;
   assign b_acc     = ready & b_en;
   assign a_we      = a_acc & a_wr;
   assign b_we      = b_acc & b_wr;
   assign coll_d    = a_we & b_we & (a_addr == b_addr);
   assign coll      = coll_q;

`ifdef BRAM_TDP_PIPE_PARITY_EN
   assign a_word = {even_parity(PAR_MAX_W'(a_din)), a_din};
   assign b_word = {even_parity(PAR_MAX_W'(b_din)), b_din};
`else
   assign a_word = a_din;
   assign b_word = b_din;
`endif

   // Port A wins a same-address write; cross-port reads see pre-edge contents.
   always @(posedge clk) begin
      if (clr_we) mem[clr_addr_q] <= '0;
      if (b_we && !coll_d) mem[b_addr] <= b_word;
      if (a_we) mem[a_addr] <= a_word;
   end

   logic         a_pv, b_pv, a_rv, b_rv;
   logic [W-1:0] a_pd, b_pd, a_rd, b_rd;

   assign a_pv = (a_acc & ~a_wr) | (a_we & WF);
   assign b_pv = (b_acc & ~b_wr) | (b_we & WF);
   assign a_pd = a_wr ? a_word : mem[a_addr];
   assign b_pd = b_wr ? b_word : mem[b_addr];

   bram_rd_pipe #(.W(W), .LAT(RD_LATENCY)) u_pipe_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (a_pv),
      .data_i  (a_pd),
      .valid_o (a_rv),
      .data_o  (a_rd)
   );

   bram_rd_pipe #(.W(W), .LAT(RD_LATENCY)) u_pipe_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (b_pv),
      .data_i  (b_pd),
      .valid_o (b_rv),
      .data_o  (b_rd)
   );

   assign a_valid = a_rv;
   assign b_valid = b_rv;
   assign a_dout  = a_rd[DATA-1:0];
   assign b_dout  = b_rd[DATA-1:0];

`ifdef BRAM_TDP_PIPE_PARITY_EN
   assign a_perr = a_rv & (even_parity(PAR_MAX_W'(a_rd[DATA-1:0])) ^ a_rd[DATA]);
   assign b_perr = b_rv & (even_parity(PAR_MAX_W'(b_rd[DATA-1:0])) ^ b_rd[DATA]);
`endif

endmodule

// File: tb/tb_bram_tdp_pipe.sv
// Directed self-checking bench for bram_tdp_pipe (ADDR=4, DATA=8, RD_LATENCY=3).
module tb_bram_tdp_pipe;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int LAT   = 3;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_busy;
   logic          a_en, a_wr, b_en, b_wr;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din, a_dout, b_dout;
   logic          a_valid, b_valid, coll;
`ifdef BRAM_TDP_PIPE_PARITY_EN
   logic          a_perr, b_perr;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] model [DEPTH];

   always #5 clk = ~clk;

   bram_tdp_pipe #(
      .STAGE_ID(0), .DATA(DW), .ADDR(AW), .RD_LATENCY(LAT),
      .WRITE_FIRST(0), .CLEAR_ON_RESET(1), .MEMINIT(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
      .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout), .a_valid(a_valid),
      .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout), .b_valid(b_valid),
`ifdef BRAM_TDP_PIPE_PARITY_EN
      .a_perr(a_perr), .b_perr(b_perr),
`endif
      .coll(coll)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      a_en = 1'b0; a_wr = 1'b0; b_en = 1'b0; b_wr = 1'b0;
   endtask

   task automatic wr(input bit port_b, input int addr, input int data);
      if (port_b) begin
         b_en = 1'b1; b_wr = 1'b1; b_addr = AW'(addr); b_din = DW'(data);
      end else begin
         a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(addr); a_din = DW'(data);
      end
      tick();
      idle();
      model[addr] = DW'(data);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle();
      a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
      #12;
      n_cmp++;
      if ({init_busy, a_valid, b_valid, coll} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_flags: got busy/av/bv/coll=%b want 1000",
                  {init_busy, a_valid, b_valid, coll});
      end
      n_cmp++;
      if ({a_dout, b_dout} !== '0) begin
         n_bad++;
         $display("FAIL reset_dout: got a=%h b=%h want 0/0", a_dout, b_dout);
      end
   endtask

   // Both ports stream reads of every address (B in reverse) and compare against the model.
   task automatic test_read_all(input string tag);
      for (int j = 0; j < DEPTH + LAT; j++) begin
         if (j < DEPTH) begin
            a_en = 1'b1; a_wr = 1'b0; a_addr = AW'(j);
            b_en = 1'b1; b_wr = 1'b0; b_addr = AW'(DEPTH - 1 - j);
         end else begin
            idle();
         end
         tick();
         if (j >= LAT - 1 && j - (LAT - 1) < DEPTH) begin
            n_cmp++;
            if (a_valid !== 1'b1 || a_dout !== model[j-(LAT-1)]) begin
               n_bad++;
               $display("FAIL %s_a[%0d]: got v=%b d=%h want v=1 d=%h", tag, j-(LAT-1),
                        a_valid, a_dout, model[j-(LAT-1)]);
            end
            n_cmp++;
            if (b_valid !== 1'b1 || b_dout !== model[DEPTH-1-(j-(LAT-1))]) begin
               n_bad++;
               $display("FAIL %s_b[%0d]: got v=%b d=%h want v=1 d=%h", tag,
                        DEPTH-1-(j-(LAT-1)), b_valid, b_dout, model[DEPTH-1-(j-(LAT-1))]);
            end
         end else begin
            n_cmp++;
            if ({a_valid, b_valid} !== 2'b00) begin
               n_bad++;
               $display("FAIL %s_idle_valid cyc %0d: got %b want 00", tag, j, {a_valid, b_valid});
            end
         end
      end
   endtask

   // Counts busy cycles from the current point while hammering both ports.
   task automatic count_busy(input string tag);
      int  cnt = 0;
      bit  saw_valid = 1'b0;
      a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(3); a_din = 8'h55;
      b_en = 1'b1; b_wr = 1'b0; b_addr = AW'(3);
      while (init_busy && cnt < 100) begin
         if (a_valid || b_valid) saw_valid = 1'b1;
         tick();
         cnt++;
      end
      idle();
      for (int k = 0; k < LAT; k++) begin
         if (a_valid || b_valid) saw_valid = 1'b1;
         tick();
      end
      n_cmp++;
      if (cnt !== 16) begin
         n_bad++;
         $display("FAIL %s_busy_len: got %0d cycles want 16", tag, cnt);
      end
      n_cmp++;
      if (saw_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_busy_valid: got valid=%b want 0", tag, saw_valid);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic test_clear;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_busy("clear");
      test_read_all("clear_rd");
   endtask

   task automatic test_latency;
      logic [AW-1:0] seq [3];
      wr(1'b0, 5, 'h12);
      a_en = 1'b1; a_wr = 1'b0; a_addr = AW'(5);
      tick();
      idle();
      n_cmp++;
      if (a_valid !== 1'b0) begin
         n_bad++; $display("FAIL lat_t1: got valid=%b want 0", a_valid);
      end
      tick();
      n_cmp++;
      if (a_valid !== 1'b0) begin
         n_bad++; $display("FAIL lat_t2: got valid=%b want 0", a_valid);
      end
      tick();
      n_cmp++;
      if (a_valid !== 1'b1 || a_dout !== 8'h12) begin
         n_bad++; $display("FAIL lat_t3: got v=%b d=%h want v=1 d=12", a_valid, a_dout);
      end
      tick();
      n_cmp++;
      if (a_valid !== 1'b0 || a_dout !== 8'h12) begin
         n_bad++; $display("FAIL lat_hold: got v=%b d=%h want v=0 d=12", a_valid, a_dout);
      end
      wr(1'b1, 1, 'h11);
      wr(1'b1, 2, 'h22);
      wr(1'b1, 3, 'h33);
      seq[0] = AW'(2); seq[1] = AW'(3); seq[2] = AW'(1);
      for (int j = 0; j < 3 + LAT; j++) begin
         if (j < 3) begin
            a_en = 1'b1; a_wr = 1'b0; a_addr = seq[j];
         end else begin
            idle();
         end
         tick();
         if (j >= LAT - 1 && j - (LAT - 1) < 3) begin
            n_cmp++;
            if (a_valid !== 1'b1 || a_dout !== model[seq[j-(LAT-1)]]) begin
               n_bad++;
               $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", j-(LAT-1),
                        a_valid, a_dout, model[seq[j-(LAT-1)]]);
            end
         end
      end
   endtask

   task automatic test_collision;
      a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(7); a_din = 8'hAA;
      b_en = 1'b1; b_wr = 1'b1; b_addr = AW'(7); b_din = 8'hBB;
      tick();
      idle();
      model[7] = 8'hAA;
      n_cmp++;
      if (coll !== 1'b1) begin
         n_bad++; $display("FAIL coll_pulse: got %b want 1", coll);
      end
      a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(10); a_din = 8'h3C;
      b_en = 1'b1; b_wr = 1'b1; b_addr = AW'(11); b_din = 8'hC3;
      tick();
      idle();
      model[10] = 8'h3C; model[11] = 8'hC3;
      n_cmp++;
      if (coll !== 1'b0) begin
         n_bad++; $display("FAIL coll_single: got %b want 0", coll);
      end
      tick();
      n_cmp++;
      if (coll !== 1'b0) begin
         n_bad++; $display("FAIL coll_diff_addr: got %b want 0", coll);
      end
      a_en = 1'b1; a_addr = AW'(7);  b_en = 1'b1; b_addr = AW'(11);
      tick();
      a_addr = AW'(10); b_addr = AW'(7);
      tick();
      idle();
      tick();
      n_cmp++;
      if (a_dout !== 8'hAA || b_dout !== 8'hC3 || {a_valid, b_valid} !== 2'b11) begin
         n_bad++;
         $display("FAIL coll_rd1: got a=%h b=%h v=%b want a=aa b=c3 v=11", a_dout, b_dout,
                  {a_valid, b_valid});
      end
      tick();
      n_cmp++;
      if (a_dout !== 8'h3C || b_dout !== 8'hAA) begin
         n_bad++; $display("FAIL coll_rd2: got a=%h b=%h want a=3c b=aa", a_dout, b_dout);
      end
   endtask

   task automatic test_read_first;
      wr(1'b0, 9, 'h01);
      a_en = 1'b1; a_wr = 1'b1; a_addr = AW'(9); a_din = 8'h02;
      b_en = 1'b1; b_wr = 1'b0; b_addr = AW'(9);
      tick();
      idle();
      model[9] = 8'h02;
      tick();
      tick();
      n_cmp++;
      if (b_valid !== 1'b1 || b_dout !== 8'h01 || a_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_first: got bv=%b bd=%h av=%b want bv=1 bd=01 av=0",
                  b_valid, b_dout, a_valid);
      end
      a_en = 1'b1; a_addr = AW'(9); b_en = 1'b1; b_addr = AW'(9);
      tick();
      idle();
      tick();
      tick();
      n_cmp++;
      if (b_dout !== 8'h02 || a_dout !== 8'h02 || {a_valid, b_valid} !== 2'b11) begin
         n_bad++;
         $display("FAIL dual_rd: got a=%h b=%h v=%b want a=02 b=02 v=11", a_dout, b_dout,
                  {a_valid, b_valid});
      end
      n_cmp++;
      if (coll !== 1'b0) begin
         n_bad++; $display("FAIL dual_rd_coll: got %b want 0", coll);
      end
   endtask

   task automatic test_reset_mid_clear;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (init_busy !== 1'b1 || a_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_rst_flags: got busy=%b av=%b want 1/0", init_busy, a_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_busy("mid");
      test_read_all("mid_rd");
   endtask

`ifdef BRAM_TDP_PIPE_PARITY_EN
   task automatic test_parity;
      wr(1'b0, 4, 'h0F);
      wr(1'b0, 6, 'h03);
      dut.mem[4][0] = ~dut.mem[4][0];
      a_en = 1'b1; a_wr = 1'b0; a_addr = AW'(4);
      tick();
      a_addr = AW'(6);
      tick();
      idle();
      tick();
      n_cmp++;
      if (a_valid !== 1'b1 || a_perr !== 1'b1 || a_dout !== 8'h0E) begin
         n_bad++;
         $display("FAIL perr_flip: got v=%b perr=%b d=%h want 1/1/0e", a_valid, a_perr, a_dout);
      end
      tick();
      n_cmp++;
      if (a_valid !== 1'b1 || a_perr !== 1'b0 || a_dout !== 8'h03) begin
         n_bad++;
         $display("FAIL perr_clean: got v=%b perr=%b d=%h want 1/0/03", a_valid, a_perr, a_dout);
      end
      tick();
      n_cmp++;
      if ({a_perr, b_perr} !== 2'b00) begin
         n_bad++; $display("FAIL perr_idle: got %b want 00", {a_perr, b_perr});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_latency();
      test_collision();
      test_read_first();
      test_reset_mid_clear();
`ifdef BRAM_TDP_PIPE_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
